// File: rtl/bounded_deque.sv
// Bounded double-ended queue on a circular buffer with head index and count.
// Define BOUNDED_DEQUE_ERR_EN to add the sticky err output.
module bounded_deque #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_front,
   input  logic                       push_back,
   input  logic                       pop_front,
   input  logic                       pop_back,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           front,
   output logic [WIDTH-1:0]           back,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
`ifdef BOUNDED_DEQUE_ERR_EN
   ,
   output logic                       err
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam logic [SW-1:0] D_S    = SW'(DEPTH);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [IW-1:0] LAST_I = IW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IW-1:0]    head_q, head_p, head_n, wr_idx, tail;
   logic [CW-1:0]    count_q, cnt_p, cnt_n;
   logic             pop_f, pop_b, push_f, push_b;
   logic             do_pop, do_push;

   // Sums here stay below 2*DEPTH, so one conditional subtract wraps them.
   function automatic logic [IW-1:0] wrap(input logic [SW-1:0] v);
      return (v >= D_S) ? IW'(v - D_S) : IW'(v);
   endfunction

   function automatic logic [IW-1:0] inc(input logic [IW-1:0] h);
      return (h == LAST_I) ? '0 : h + IW'(1);
   endfunction

   function automatic logic [IW-1:0] dec(input logic [IW-1:0] h);
      return (h == '0) ? LAST_I : h - IW'(1);
   endfunction

   always_comb begin
      pop_f   = pop_front;
      pop_b   = pop_back & ~pop_front;
      push_f  = push_front;
      push_b  = push_back & ~push_front;
      do_pop  = (pop_f | pop_b) && (count_q != '0);
      head_p  = head_q;
      cnt_p   = count_q;
      if (do_pop) begin
         cnt_p = count_q - ONE_C;
         if (pop_f) head_p = inc(head_q);
      end
      // Push sees the post-pop occupancy.
      do_push = (push_f | push_b) && (cnt_p != FULL_C);
      head_n  = head_p;
      cnt_n   = cnt_p;
      wr_idx  = head_p;
      if (do_push) begin
         cnt_n = cnt_p + ONE_C;
         if (push_f) begin
            head_n = dec(head_p);
            wr_idx = dec(head_p);
         end else begin
            wr_idx = wrap(SW'(head_p) + SW'(cnt_p));
         end
      end
   end

   always_comb begin
      tail = head_q;
      if (count_q != '0)
         tail = wrap(SW'(head_q) + SW'(count_q) - SW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_n;
         count_q <= cnt_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_idx] <= din;
   end

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_C);
   assign front = empty ? '0 : mem[head_q];
   assign back  = empty ? '0 : mem[tail];

`ifdef BOUNDED_DEQUE_ERR_EN
   logic err_ev;
   logic err_q;

   assign err_ev = ((push_f | push_b) & ~do_push)
                 | ((pop_f | pop_b) & (count_q == '0));

   always_ff @(posedge clk) begin
      if (rst)         err_q <= 1'b0;
      else if (err_ev) err_q <= 1'b1;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_bounded_deque.sv
// Directed self-checking bench for bounded_deque (WIDTH=8, DEPTH=5).
module tb_bounded_deque;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push_front = 1'b0;
   logic       push_back = 1'b0;
   logic       pop_front = 1'b0;
   logic       pop_back = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] front;
   logic [7:0] back;
   logic [2:0] count;
   logic       empty;
   logic       full;
`ifdef BOUNDED_DEQUE_ERR_EN
   logic       err;
`endif

   int passed = 0;
   int total  = 0;

   bounded_deque #(.WIDTH(8), .DEPTH(5)) dut (
      .clk(clk),
      .rst(rst),
      .push_front(push_front),
      .push_back(push_back),
      .pop_front(pop_front),
      .pop_back(pop_back),
      .din(din),
      .front(front),
      .back(back),
      .count(count),
      .empty(empty),
      .full(full)
`ifdef BOUNDED_DEQUE_ERR_EN
      ,
      .err(err)
`endif
   );

   always #5 clk = ~clk;

   // One clock with the given inputs; outputs settle #1 after the edge.
   task automatic cyc(input logic r, input logic pf, input logic pb,
                      input logic qf, input logic qb, input logic [7:0] d);
      @(negedge clk);
      rst = r; push_front = pf; push_back = pb;
      pop_front = qf; pop_back = qb; din = d;
      @(posedge clk);
      #1;
      rst = 0; push_front = 0; push_back = 0;
      pop_front = 0; pop_back = 0; din = '0;
   endtask

   task automatic fill_15();
      cyc(1, 0, 0, 0, 0, 8'h00);
      for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 0, 8'(i));
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0, 8'h00);
      total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
      total++; if (empty !== 1'b1) $display("FAIL rst_empty got %0b exp 1", empty); else passed++;
      total++; if (full !== 1'b0) $display("FAIL rst_full got %0b exp 0", full); else passed++;
      total++; if (front !== 8'h00) $display("FAIL rst_front got %h exp 00", front); else passed++;
      total++; if (back !== 8'h00) $display("FAIL rst_back got %h exp 00", back); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b0) $display("FAIL rst_err got %0b exp 0", err); else passed++;
`endif
   endtask

   task automatic test_push_back();
      cyc(0, 0, 1, 0, 0, 8'h11);
      total++; if (front !== 8'h11 || back !== 8'h11 || count !== 3'd1)
         $display("FAIL pb_first got %h/%h/%0d exp 11/11/1", front, back, count); else passed++;
      cyc(0, 0, 1, 0, 0, 8'h22);
      cyc(0, 0, 1, 0, 0, 8'h33);
      total++; if (front !== 8'h11) $display("FAIL pb_front got %h exp 11", front); else passed++;
      total++; if (back !== 8'h33) $display("FAIL pb_back got %h exp 33", back); else passed++;
      total++; if (count !== 3'd3) $display("FAIL pb_count got %0d exp 3", count); else passed++;
   endtask

   task automatic test_push_front_pop_back();
      cyc(0, 1, 0, 0, 0, 8'h44);
      total++; if (front !== 8'h44 || back !== 8'h33 || count !== 3'd4)
         $display("FAIL pf got %h/%h/%0d exp 44/33/4", front, back, count); else passed++;
      cyc(0, 0, 0, 0, 1, 8'h00);
      total++; if (back !== 8'h22 || count !== 3'd3)
         $display("FAIL popb1 got %h/%0d exp 22/3", back, count); else passed++;
      cyc(0, 0, 0, 0, 1, 8'h00);
      total++; if (front !== 8'h44 || back !== 8'h11 || count !== 3'd2)
         $display("FAIL popb2 got %h/%h/%0d exp 44/11/2", front, back, count); else passed++;
   endtask

   task automatic test_full_discard();
      fill_15();
      total++; if (count !== 3'd5 || full !== 1'b1)
         $display("FAIL fill got %0d/%0b exp 5/1", count, full); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b0) $display("FAIL fill_err got %0b exp 0", err); else passed++;
`endif
      cyc(0, 0, 1, 0, 0, 8'h06);
      total++; if (count !== 3'd5 || back !== 8'h05 || front !== 8'h01)
         $display("FAIL discard got %h/%h/%0d exp 01/05/5", front, back, count); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b1) $display("FAIL discard_err got %0b exp 1", err); else passed++;
`endif
   endtask

   task automatic test_full_rotate();
      fill_15();
      cyc(0, 0, 1, 1, 0, 8'h06);
      total++; if (front !== 8'h02 || back !== 8'h06 || count !== 3'd5 || full !== 1'b1)
         $display("FAIL rot_f got %h/%h/%0d/%0b exp 02/06/5/1", front, back, count, full); else passed++;
      cyc(0, 1, 0, 0, 1, 8'h07);
      total++; if (front !== 8'h07 || back !== 8'h05 || count !== 3'd5)
         $display("FAIL rot_b got %h/%h/%0d exp 07/05/5", front, back, count); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b0) $display("FAIL rot_err got %0b exp 0", err); else passed++;
`endif
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [5];
      exp_q = '{8'h07, 8'h02, 8'h03, 8'h04, 8'h05};
      for (int i = 0; i < 5; i++) begin
         total++; if (front !== exp_q[i])
            $display("FAIL drain_%0d got %h exp %h", i, front, exp_q[i]); else passed++;
         cyc(0, 0, 0, 1, 0, 8'h00);
      end
      total++; if (empty !== 1'b1 || front !== 8'h00 || back !== 8'h00)
         $display("FAIL drained got %0b/%h/%h exp 1/00/00", empty, front, back); else passed++;
   endtask

   task automatic test_empty_pop_push();
      cyc(1, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 1, 0, 8'h7A);
      total++; if (count !== 3'd1 || front !== 8'h7A || back !== 8'h7A)
         $display("FAIL empop got %h/%h/%0d exp 7A/7A/1", front, back, count); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b1) $display("FAIL empop_err got %0b exp 1", err); else passed++;
`endif
      cyc(0, 0, 1, 1, 0, 8'h5B);
      total++; if (count !== 3'd1 || front !== 8'h5B || back !== 8'h5B)
         $display("FAIL one_swap got %h/%h/%0d exp 5B/5B/1", front, back, count); else passed++;
      cyc(0, 1, 1, 0, 0, 8'h99);
      total++; if (count !== 3'd2 || front !== 8'h99 || back !== 8'h5B)
         $display("FAIL push_prio got %h/%h/%0d exp 99/5B/2", front, back, count); else passed++;
      cyc(0, 0, 0, 1, 1, 8'h00);
      total++; if (count !== 3'd1 || front !== 8'h5B || back !== 8'h5B)
         $display("FAIL pop_prio got %h/%h/%0d exp 5B/5B/1", front, back, count); else passed++;
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 8'hA1);
      cyc(0, 0, 1, 0, 0, 8'hA2);
      cyc(0, 0, 0, 1, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 8'hA3);
      cyc(0, 0, 1, 0, 0, 8'hA4);
`ifdef BOUNDED_DEQUE_ERR_EN
      cyc(0, 0, 0, 0, 0, 8'h00);
`endif
      total++; if (count !== 3'd3 || front !== 8'hA2 || back !== 8'hA4)
         $display("FAIL pre_rst got %h/%h/%0d exp A2/A4/3", front, back, count); else passed++;
      cyc(1, 0, 1, 1, 0, 8'h55);
      total++; if (count !== 3'd0 || empty !== 1'b1 || front !== 8'h00 || back !== 8'h00)
         $display("FAIL mid_rst got %h/%h/%0d/%0b exp 00/00/0/1", front, back, count, empty); else passed++;
`ifdef BOUNDED_DEQUE_ERR_EN
      total++; if (err !== 1'b0) $display("FAIL mid_rst_err got %0b exp 0", err); else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_push_back();
      test_push_front_pop_back();
      test_full_discard();
      test_full_rotate();
      test_back_to_back();
      test_empty_pop_push();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
